// File: rtl/ram_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : ram_port_arbiter
// Purpose  : Fixed-priority (INIT > DATA > FETCH) sharing of one RAM, with a
//            starvation guard that lets a waiting FETCH beat DATA.
// Revision : 1.0 - initial release
// =============================================================================
module ram_port_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init_req,
    input  logic [ADDRESS_WIDTH-1:0] init_adrs,
    input  logic [DATA_WIDTH-1:0]    init_wdata,
    output logic                     init_gnt,
    input  logic                     fetch_req,
    input  logic [ADDRESS_WIDTH-1:0] fetch_adrs,
    output logic                     fetch_gnt,
    output logic                     fetch_rvalid,
    input  logic                     data_req,
    input  logic                     data_we,
    input  logic [ADDRESS_WIDTH-1:0] data_adrs,
    input  logic [DATA_WIDTH-1:0]    data_wdata,
    output logic                     data_gnt,
    output logic                     data_rvalid,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     ram_w_en,
    output logic                     ram_r_en,
    output logic [ADDRESS_WIDTH-1:0] ram_w_adrs,
    output logic [ADDRESS_WIDTH-1:0] ram_r_adrs,
    output logic [DATA_WIDTH-1:0]    ram_w_data,
    input  logic [DATA_WIDTH-1:0]    ram_r_data,
    output logic                     busy
);

    localparam int c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDATA  = 2'd2
    } state_t;

    state_t                     r_state, w_state_next;
    logic [c_CNT_W-1:0]         r_starve_cnt, w_starve_cnt_next;
    logic                       r_init_gnt, w_init_gnt_next;
    logic                       r_fetch_gnt, w_fetch_gnt_next;
    logic                       r_data_gnt, w_data_gnt_next;
    logic                       r_fetch_rvalid, w_fetch_rvalid_next;
    logic                       r_data_rvalid, w_data_rvalid_next;
    logic                       r_ram_w_en, w_ram_w_en_next;
    logic                       r_ram_r_en, w_ram_r_en_next;
    logic [ADDRESS_WIDTH-1:0]   r_ram_w_adrs, w_ram_w_adrs_next;
    logic [ADDRESS_WIDTH-1:0]   r_ram_r_adrs, w_ram_r_adrs_next;
    logic [DATA_WIDTH-1:0]      r_ram_w_data, w_ram_w_data_next;
    logic [DATA_WIDTH-1:0]      r_rdata, w_rdata_next;
    logic                       r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_starve_cnt   <= '0;
            r_init_gnt     <= 1'b0;
            r_fetch_gnt    <= 1'b0;
            r_data_gnt     <= 1'b0;
            r_fetch_rvalid <= 1'b0;
            r_data_rvalid  <= 1'b0;
            r_ram_w_en     <= 1'b0;
            r_ram_r_en     <= 1'b0;
            r_ram_w_adrs   <= '0;
            r_ram_r_adrs   <= '0;
            r_ram_w_data   <= '0;
            r_rdata        <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_starve_cnt   <= w_starve_cnt_next;
            r_init_gnt     <= w_init_gnt_next;
            r_fetch_gnt    <= w_fetch_gnt_next;
            r_data_gnt     <= w_data_gnt_next;
            r_fetch_rvalid <= w_fetch_rvalid_next;
            r_data_rvalid  <= w_data_rvalid_next;
            r_ram_w_en     <= w_ram_w_en_next;
            r_ram_r_en     <= w_ram_r_en_next;
            r_ram_w_adrs   <= w_ram_w_adrs_next;
            r_ram_r_adrs   <= w_ram_r_adrs_next;
            r_ram_w_data   <= w_ram_w_data_next;
            r_rdata        <= w_rdata_next;
            r_busy         <= (w_state_next != ST_IDLE);
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_starve_cnt_next   = r_starve_cnt;
        w_init_gnt_next     = 1'b0;
        w_fetch_gnt_next    = 1'b0;
        w_data_gnt_next     = 1'b0;
        w_fetch_rvalid_next = 1'b0;
        w_data_rvalid_next  = 1'b0;
        w_ram_w_en_next     = 1'b0;
        w_ram_r_en_next     = 1'b0;
        w_ram_w_adrs_next   = '0;
        w_ram_r_adrs_next   = '0;
        w_ram_w_data_next   = '0;
        w_rdata_next        = r_rdata;

        case (r_state)
            ST_IDLE: begin
                if (!fetch_req) begin
                    w_starve_cnt_next = '0;
                end
                if (init_req) begin
                    w_state_next      = ST_ACCESS;
                    w_init_gnt_next   = 1'b1;
                    w_ram_w_en_next   = 1'b1;
                    w_ram_w_adrs_next = init_adrs;
                    w_ram_w_data_next = init_wdata;
                end else if (fetch_req && (!data_req || r_starve_cnt == c_CNT_MAX)) begin
                    w_state_next      = ST_ACCESS;
                    w_fetch_gnt_next  = 1'b1;
                    w_ram_r_en_next   = 1'b1;
                    w_ram_r_adrs_next = fetch_adrs;
                    w_starve_cnt_next = '0;
                end else if (data_req) begin
                    w_state_next    = ST_ACCESS;
                    w_data_gnt_next = 1'b1;
                    if (data_we) begin
                        w_ram_w_en_next   = 1'b1;
                        w_ram_w_adrs_next = data_adrs;
                        w_ram_w_data_next = data_wdata;
                    end else begin
                        w_ram_r_en_next   = 1'b1;
                        w_ram_r_adrs_next = data_adrs;
                    end
                    if (fetch_req && r_starve_cnt != c_CNT_MAX) begin
                        w_starve_cnt_next = r_starve_cnt + 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // The grant registers still identify the owner of the read.
                if (r_ram_r_en) begin
                    w_state_next        = ST_RDATA;
                    w_fetch_rvalid_next = r_fetch_gnt;
                    w_data_rvalid_next  = r_data_gnt;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RDATA: begin
                w_rdata_next = ram_r_data;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // RAM output register is the data stage: forward it while rvalid is up, hold it afterwards.
    assign rdata        = (r_state == ST_RDATA) ? ram_r_data : r_rdata;
    assign init_gnt     = r_init_gnt;
    assign fetch_gnt    = r_fetch_gnt;
    assign data_gnt     = r_data_gnt;
    assign fetch_rvalid = r_fetch_rvalid;
    assign data_rvalid  = r_data_rvalid;
    assign ram_w_en     = r_ram_w_en;
    assign ram_r_en     = r_ram_r_en;
    assign ram_w_adrs   = r_ram_w_adrs;
    assign ram_r_adrs   = r_ram_r_adrs;
    assign ram_w_data   = r_ram_w_data;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Directed stimulus with a queue-based scoreboard for ram_port_arbiter.
// Revision : 1.0 - initial release
// =============================================================================
module tb_ram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_req, fetch_req, data_req, data_we;
    logic [AW-1:0] init_adrs, fetch_adrs, data_adrs;
    logic [DW-1:0] init_wdata, data_wdata;
    logic          init_gnt, fetch_gnt, fetch_rvalid, data_gnt, data_rvalid;
    logic [DW-1:0] rdata, ram_w_data, ram_r_data;
    logic          ram_w_en, ram_r_en, busy;
    logic [AW-1:0] ram_w_adrs, ram_r_adrs;

    ram_port_arbiter #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARVE_LIMIT(3)
    ) dut (
        .clk(clk), .reset(reset),
        .init_req(init_req), .init_adrs(init_adrs), .init_wdata(init_wdata), .init_gnt(init_gnt),
        .fetch_req(fetch_req), .fetch_adrs(fetch_adrs), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid),
        .data_req(data_req), .data_we(data_we), .data_adrs(data_adrs), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid), .rdata(rdata),
        .ram_w_en(ram_w_en), .ram_r_en(ram_r_en), .ram_w_adrs(ram_w_adrs),
        .ram_r_adrs(ram_r_adrs), .ram_w_data(ram_w_data), .ram_r_data(ram_r_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears the cycle after ram_r_en.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_w_en) mem[ram_w_adrs] <= ram_w_data;
        if (ram_r_en) ram_r_data <= mem[ram_r_adrs];
    end

    // port one-hot = {init, data, fetch}
    typedef struct {
        bit            rv;
        logic [2:0]    port;
        logic          we;
        logic [AW-1:0] adrs;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_gnt(input logic [2:0] port, input logic we,
                            input logic [AW-1:0] adrs, input logic [DW-1:0] data);
        exp_t e;
        e.rv = 1'b0; e.port = port; e.we = we; e.adrs = adrs; e.data = data;
        sb.push_back(e);
    endtask

    task automatic push_rv(input logic [2:0] port, input logic [DW-1:0] data);
        exp_t e;
        e.rv = 1'b1; e.port = port; e.we = 1'b0; e.adrs = '0; e.data = data;
        sb.push_back(e);
    endtask

    // Monitor: every grant or rvalid the DUT shows is matched against the queue head.
    initial begin
        forever begin
            logic [2:0] g, v;
            exp_t       e;
            @(negedge clk);
            g = {init_gnt, data_gnt, fetch_gnt};
            v = {1'b0, data_rvalid, fetch_rvalid};
            if (!reset && (g != 3'b000 || v != 3'b000)) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: got gnt=%b rvalid=%b, expected no event", g, v);
                end else begin
                    e = sb.pop_front();
                    if (!e.rv) begin
                        check("gnt_vector", {61'd0, g}, {61'd0, e.port});
                        check("gnt_no_rvalid", {61'd0, v}, 64'd0);
                        check("gnt_strobes", {62'd0, ram_w_en, ram_r_en}, {62'd0, e.we, ~e.we});
                        if (e.we) begin
                            check("gnt_w_adrs", {52'd0, ram_w_adrs}, {52'd0, e.adrs});
                            check("gnt_w_data", {32'd0, ram_w_data}, {32'd0, e.data});
                        end else begin
                            check("gnt_r_adrs", {52'd0, ram_r_adrs}, {52'd0, e.adrs});
                        end
                    end else begin
                        check("rvalid_vector", {61'd0, v}, {61'd0, e.port});
                        check("rvalid_no_gnt", {61'd0, g}, 64'd0);
                        check("rvalid_rdata", {32'd0, rdata}, {32'd0, e.data});
                    end
                end
            end
        end
    end

    // Waits (bounded) for the selected grant, then drops that request. sel: 0 init, 1 data, 2 fetch.
    task automatic serve(input int sel);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            case (sel)
                0: if (init_gnt)  begin init_req  = 1'b0; seen = 1'b1; end
                1: if (data_gnt)  begin data_req  = 1'b0; seen = 1'b1; end
                default: if (fetch_gnt) begin fetch_req = 1'b0; seen = 1'b1; end
            endcase
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL gnt_timeout: port %0d got no grant, expected one within 40 cycles", sel);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int f_cnt;
        reset = 1'b1;
        init_req = 1'b0; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        init_adrs = '0; fetch_adrs = '0; data_adrs = '0;
        init_wdata = '0; data_wdata = '0;
        idle_cycles(3);
        check("reset_outputs",
              {31'd0, busy, init_gnt, fetch_gnt, data_gnt, fetch_rvalid, data_rvalid, ram_w_en, ram_r_en},
              64'd0);
        check("reset_rdata", {32'd0, rdata}, 64'd0);
        reset = 1'b0;
        idle_cycles(2);

        // INIT write: grant and write strobe in cycle 2, idle again in cycle 3
        init_adrs = 12'h005; init_wdata = 32'hDEADBEEF; init_req = 1'b1;
        push_gnt(3'b100, 1'b1, 12'h005, 32'hDEADBEEF);
        @(negedge clk);
        check("t2_init_gnt_c2", {63'd0, init_gnt}, 64'd1);
        check("t2_w_en_c2", {63'd0, ram_w_en}, 64'd1);
        check("t2_w_adrs_c2", {52'd0, ram_w_adrs}, 64'h005);
        init_req = 1'b0;
        @(negedge clk);
        check("t2_busy_c3", {63'd0, busy}, 64'd0);

        // FETCH read of the word just written
        fetch_adrs = 12'h005; fetch_req = 1'b1;
        push_gnt(3'b001, 1'b0, 12'h005, '0);
        push_rv(3'b001, 32'hDEADBEEF);
        @(negedge clk);
        check("t3_fetch_gnt_c2", {63'd0, fetch_gnt}, 64'd1);
        fetch_req = 1'b0;
        @(negedge clk);
        check("t3_fetch_rvalid_c3", {63'd0, fetch_rvalid}, 64'd1);
        @(negedge clk);
        check("t3_busy_after", {63'd0, busy}, 64'd0);

        // Simultaneous requests: INIT, then DATA, then FETCH
        init_adrs = 12'h030; init_wdata = 32'hA5A5A5A5;
        data_adrs = 12'h031; data_wdata = 32'h0000BEEF; data_we = 1'b1;
        fetch_adrs = 12'h005;
        push_gnt(3'b100, 1'b1, 12'h030, 32'hA5A5A5A5);
        push_gnt(3'b010, 1'b1, 12'h031, 32'h0000BEEF);
        push_gnt(3'b001, 1'b0, 12'h005, '0);
        push_rv(3'b001, 32'hDEADBEEF);
        init_req = 1'b1; data_req = 1'b1; fetch_req = 1'b1;
        fork
            serve(0);
            serve(1);
            serve(2);
        join
        idle_cycles(4);

        // DATA and FETCH held: D D D F, repeated
        data_adrs = 12'h040; data_wdata = 32'h11110000; data_we = 1'b1;
        fetch_adrs = 12'h005;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) push_gnt(3'b010, 1'b1, 12'h040, 32'h11110000);
            push_gnt(3'b001, 1'b0, 12'h005, '0);
            push_rv(3'b001, 32'hDEADBEEF);
        end
        data_req = 1'b1; fetch_req = 1'b1;
        f_cnt = 0;
        for (int i = 0; i < 60 && f_cnt < 2; i++) begin
            @(negedge clk);
            if (fetch_gnt) f_cnt++;
        end
        data_req = 1'b0; fetch_req = 1'b0;
        check("t5_fetch_grants", 64'(f_cnt), 64'd2);
        idle_cycles(4);

        // DATA store then load of the same word
        data_adrs = 12'h010; data_wdata = 32'h12345678; data_we = 1'b1; data_req = 1'b1;
        push_gnt(3'b010, 1'b1, 12'h010, 32'h12345678);
        serve(1);
        @(negedge clk);
        data_we = 1'b0; data_req = 1'b1;
        push_gnt(3'b010, 1'b0, 12'h010, '0);
        push_rv(3'b010, 32'h12345678);
        serve(1);
        idle_cycles(4);
        check("t6_rdata_held", {32'd0, rdata}, {32'd0, 32'h12345678});

        // Reset while in RDATA: everything clears at once and no rvalid follows
        fetch_adrs = 12'h010; fetch_req = 1'b1;
        push_gnt(3'b001, 1'b0, 12'h010, '0);
        serve(2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t1_reset_outputs",
              {31'd0, busy, init_gnt, fetch_gnt, data_gnt, fetch_rvalid, data_rvalid, ram_w_en, ram_r_en},
              64'd0);
        check("t1_reset_rdata", {32'd0, rdata}, 64'd0);
        idle_cycles(2);
        reset = 1'b0;
        idle_cycles(5);
        check("t1_busy_after_reset", {63'd0, busy}, 64'd0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
